// File: rtl/mac_pipe.sv
// mac_pipe: three-stage signed multiply-add-multiply pipeline with an optional
// accumulator at the output stage and valid/ready flow control.
//
//   S1: regm = x * a
//   S2: rega = regm + sext(b)
//   S3: prod = rega * c; out <= sext(prod) (mode 0 or clr) or out + sext(prod)
//
// Ports
//   CLK        clock, all state on rising edge
//   RST        asynchronous active-high reset
//   in_valid   sample present on x/a/b/c/mode/clr
//   in_ready   block accepts a sample this cycle (combinational from out_valid/out_ready)
//   x, a, b, c signed operands (WLx/WLa/WLb/WLc bits)
//   mode       0 = plain ((x*a)+b)*c, 1 = accumulate
//   clr        in mode 1, this sample restarts the accumulator
//   out_valid  out holds a result not yet consumed
//   out_ready  downstream accepts out
//   out        signed result, WLout bits
//   sat        sticky saturation flag
//
// Configuration
//   MAC_PIPE_SAT_EN  defined: mode-1 accumulation clamps and sets sticky sat.
//                    undefined: accumulation wraps and sat is tied to 0.
module mac_pipe #(
  parameter int unsigned WLx  = 8,
  parameter int unsigned WLa  = 3,
  parameter int unsigned WLb  = 4,
  parameter int unsigned WLc  = 5,
  parameter int unsigned ACCG = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [WLx-1:0]                 x,
  input  logic signed [WLa-1:0]                 a,
  input  logic signed [WLb-1:0]                 b,
  input  logic signed [WLc-1:0]                 c,
  input  logic                                  mode,
  input  logic                                  clr,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [WLx+WLa+((WLx+WLa > WLb) ? 0 : WLb-WLx-WLa)+1+WLc+ACCG-1:0] out,
  output logic                                  sat
);

  localparam int unsigned WLregm = WLx + WLa;
  localparam int unsigned WLrega = ((WLregm > WLb) ? WLregm : WLb) + 1;
  localparam int unsigned WLp    = WLrega + WLc;
  localparam int unsigned WLout  = WLp + ACCG;

  // Stage 1 state
  logic                     v1, m1, k1;
  logic signed [WLregm-1:0] regm;
  logic signed [WLb-1:0]    b1;
  logic signed [WLc-1:0]    c1;

  // Stage 2 state
  logic                     v2, m2, k2;
  logic signed [WLrega-1:0] rega;
  logic signed [WLc-1:0]    c2;

  // Combinational stage results
  logic signed [WLregm-1:0] regm_d;
  logic signed [WLrega-1:0] rega_d;
  logic signed [WLp-1:0]    prod;
  logic signed [WLout-1:0]  prod_ext;
  logic signed [WLout-1:0]  acc;
  logic signed [WLout-1:0]  out_d;
  logic                     clamp;
  logic                     adv;

  // Whole pipe advances together; stalls only when a result is waiting unconsumed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Datapath; operands are sign-extended to the stage width so the product is exact.
  always_comb begin
    regm_d   = WLregm'(x) * WLregm'(a);
    rega_d   = WLrega'(regm) + WLrega'(b1);
    prod     = WLp'(rega) * WLp'(c2);
    prod_ext = WLout'(prod);
  end

`ifdef MAC_PIPE_SAT_EN
  localparam int unsigned WLsum = WLout + 1;
  localparam logic signed [WLout-1:0] ACC_MAX = {1'b0, {(WLout-1){1'b1}}};
  localparam logic signed [WLout-1:0] ACC_MIN = {1'b1, {(WLout-1){1'b0}}};

  logic signed [WLsum-1:0] sum_w;
  logic                    ovf;

  // One extra bit exposes overflow; the top two bits disagree exactly on overflow.
  always_comb begin
    sum_w = WLsum'(out) + WLsum'(prod_ext);
    ovf   = sum_w[WLout] ^ sum_w[WLout-1];
    acc   = sum_w[WLout-1:0];
    if (ovf) acc = sum_w[WLout] ? ACC_MIN : ACC_MAX;
    clamp = ovf && m2 && !k2;
  end

  // Sticky flag: set on any clamp committed to out, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        sat <= 1'b0;
    else if (adv && v2 && clamp)    sat <= 1'b1;
  end
`else
  always_comb begin
    acc   = out + prod_ext;
    clamp = 1'b0;
  end

  assign sat = 1'b0;
`endif

  // Output stage select: accumulate only in mode 1 without clr.
  always_comb begin
    out_d = prod_ext;
    if (m2 && !k2) out_d = acc;
  end

  // Pipeline registers; data loads only behind a valid sample so bubbles keep data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1        <= 1'b0;
      m1        <= 1'b0;
      k1        <= 1'b0;
      regm      <= '0;
      b1        <= '0;
      c1        <= '0;
      v2        <= 1'b0;
      m2        <= 1'b0;
      k2        <= 1'b0;
      rega      <= '0;
      c2        <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        regm <= regm_d;
        b1   <= b;
        c1   <= c;
        m1   <= mode;
        k1   <= clr;
      end
      if (v1) begin
        rega <= rega_d;
        c2   <= c1;
        m2   <= m1;
        k2   <= k1;
      end
      if (v2) out <= out_d;
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed self-checking bench for mac_pipe: a default instance (WLout=21)
// and an ACCG=0 instance (WLout=17) share all stimulus.
module tb_mac_pipe;

  logic               CLK;
  logic               RST;
  logic               in_valid;
  logic               mode;
  logic               clr;
  logic               out_ready;
  logic signed [7:0]  x;
  logic signed [2:0]  a;
  logic signed [3:0]  b;
  logic signed [4:0]  c;

  logic               in_ready, out_valid, sat;
  logic signed [20:0] out;
  logic               in_ready0, out_valid0, sat0;
  logic signed [16:0] out0;

  int n_checks = 0;
  int n_fail   = 0;

  mac_pipe u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .a(a), .b(b), .c(c), .mode(mode), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat)
  );

  mac_pipe #(.ACCG(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0),
    .x(x), .a(a), .b(b), .c(c), .mode(mode), .clr(clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .sat(sat0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input int xi, input int ai, input int bi,
                       input int ci, input logic md, input logic cl);
    in_valid = v;
    x        = 8'(xi);
    a        = 3'(ai);
    b        = 4'(bi);
    c        = 5'(ci);
    mode     = md;
    clr      = cl;
  endtask

  task automatic test_reset();
    RST = 1'b1; out_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out !== 21'(0)) begin n_fail++; $display("FAIL reset_out: got %0d want 0", out); end
    n_checks++; if (sat !== 1'b0 || sat0 !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b/%b want 0/0", sat, sat0); end
    n_checks++; if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, in_ready0); end
    tick(); tick();
    RST = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", out_valid); end
  endtask

  // 10*3=30, +2=32, *4=128; visible exactly three cycles after the sample is offered.
  task automatic test_plain();
    out_ready = 1'b1;
    drive(1'b1, 10, 3, 2, 4, 1'b0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL plain_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL plain_lat1: got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL plain_lat2: got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out !== 21'(128)) begin n_fail++; $display("FAIL plain_result: got v=%b %0d want v=1 128", out_valid, out); end
    tick();
  endtask

  // -128*-4=512, -8 -> 504, *-16 = -8064; then consumed with no new result.
  task automatic test_negative();
    drive(1'b1, -128, -4, -8, -16, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || out !== 21'(-8064)) begin n_fail++; $display("FAIL neg_result: got v=%b %0d want v=1 -8064", out_valid, out); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out !== 21'(-8064)) begin n_fail++; $display("FAIL neg_drop_hold: got v=%b %0d want v=0 -8064", out_valid, out); end
  endtask

  // Four back-to-back accumulating samples of product 1 -> 1,2,3,4.
  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1, 1, 0, 1, 1'b1, i == 0);
      else       in_valid = 1'b0;
      tick();
      if (i >= 2 && i <= 5) begin
        n_checks++; if (out_valid !== 1'b1 || out !== 21'(i - 1)) begin n_fail++; $display("FAIL accum_step%0d: got v=%b %0d want v=1 %0d", i - 1, out_valid, out, i - 1); end
      end
    end
    n_checks++; if (out_valid !== 1'b0 || out !== 21'(4)) begin n_fail++; $display("FAIL accum_hold: got v=%b %0d want v=0 4", out_valid, out); end
  endtask

  // Samples x=1..6 (result = x); downstream stalls for two cycles mid-stream.
  task automatic test_stall();
    int next_s = 1;
    int exp_v  = 1;
    logic signed [20:0] held = '0;
    for (int t = 0; t < 40 && exp_v <= 6; t++) begin
      out_ready = !(t == 4 || t == 5);
      if (next_s <= 6) drive(1'b1, next_s, 1, 0, 1, 1'b0, 1'b0);
      else             in_valid = 1'b0;
      #1;
      if (t == 4) begin
        held = out;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_t4: got %b want 0", in_ready); end
      end
      if (t == 5) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_t5: got %b want 0", in_ready); end
        n_checks++; if (out !== held || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_hold: got v=%b %0d want v=1 %0d", out_valid, out, held); end
      end
      if (in_valid && in_ready) next_s++;
      if (out_valid && out_ready) begin
        n_checks++; if (out !== 21'(exp_v)) begin n_fail++; $display("FAIL stall_order: got %0d want %0d", out, exp_v); end
        exp_v++;
      end
      tick();
    end
    n_checks++; if (exp_v != 7 || next_s != 7) begin n_fail++; $display("FAIL stall_count: got consumed=%0d accepted=%0d want 6/6", exp_v - 1, next_s - 1); end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
  endtask

  // Product (512+7)*-16 = -8304; 8 accumulations = -66432, overflowing 17 bits.
  task automatic test_saturation();
`ifdef MAC_PIPE_SAT_EN
    int   exp0     = -65536;
    logic exp_sat0 = 1'b1;
`else
    int   exp0     = 64640;
    logic exp_sat0 = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, -128, -4, 7, -16, 1'b1, i == 0);
      else       in_valid = 1'b0;
      tick();
      if (i == 8) begin
        n_checks++; if (out0 !== 17'(-58128)) begin n_fail++; $display("FAIL sat_7th: got %0d want -58128", out0); end
      end
    end
    n_checks++; if (out_valid0 !== 1'b1 || out0 !== 17'(exp0)) begin n_fail++; $display("FAIL sat_8th_acc0: got v=%b %0d want v=1 %0d", out_valid0, out0, exp0); end
    n_checks++; if (sat0 !== exp_sat0) begin n_fail++; $display("FAIL sat_flag_acc0: got %b want %b", sat0, exp_sat0); end
    n_checks++; if (out !== 21'(-66432) || sat !== 1'b0) begin n_fail++; $display("FAIL sat_8th_acc4: got %0d sat=%b want -66432 sat=0", out, sat); end
    tick();
  endtask

  // Async reset between edges with three samples in flight, then a clean restart.
  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5, 1, 0, 1, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out !== 21'(5)) begin n_fail++; $display("FAIL arst_pre: got v=%b %0d want v=1 5", out_valid, out); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out !== 21'(0) || out0 !== 17'(0)) begin n_fail++; $display("FAIL arst_clear: got v=%b %0d/%0d want v=0 0/0", out_valid, out, out0); end
    n_checks++; if (sat !== 1'b0 || sat0 !== 1'b0) begin n_fail++; $display("FAIL arst_sat: got %b/%b want 0/0", sat, sat0); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale%0d: got %b want 0", i, out_valid); end
    end
    // Accumulate without clr: must start from zero, (2*3+1)*2 = 14.
    drive(1'b1, 2, 3, 1, 2, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || out !== 21'(14) || out0 !== 17'(14)) begin n_fail++; $display("FAIL arst_restart: got v=%b %0d/%0d want v=1 14/14", out_valid, out, out0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_plain();
    test_negative();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
